gb_cart_mbc1: RTL and testbench



---
 rtl/gb_cart_mbc1.sv | 202 ++++++++++++++++++++
 tb/tb_gb_cart_mbc1.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_cart_mbc1.sv
// MBC1 cartridge responder for the Game Boy cartridge bus.
// Ports: bus_* (core side), mem_* (req/ack backing store), clk, rst_n.
module gb_cart_mbc1 #(
    parameter int ROM_ADDR_W = 21,
    parameter int RAM_ADDR_W = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           bus_a,
    input  logic [7:0]            bus_din,
    input  logic                  bus_rd,
    input  logic                  bus_wr,
    input  logic                  bus_cs,
    output logic [7:0]            bus_dout,
    output logic                  bus_dout_en,
    output logic                  mem_req,
    output logic                  mem_sel,
    output logic                  mem_we,
    output logic [ROM_ADDR_W-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        HOLD
    } state_t;

    state_t r_state, w_state_nxt;

    logic r_rd_s1, r_rd_s2, r_rd_d;
    logic r_wr_s1, r_wr_s2, r_wr_d;

    logic       r_ram_en, w_ram_en_nxt;
    logic [4:0] r_rom_bank_lo, w_rom_bank_lo_nxt;
    logic [1:0] r_bank_hi, w_bank_hi_nxt;
    logic       r_mode, w_mode_nxt;

    logic [7:0]            r_dout, w_dout_nxt;
    logic                  r_dout_en, w_dout_en_nxt;
    logic                  r_req, w_req_nxt;
    logic                  r_we, w_we_nxt;
    logic                  r_sel, w_sel_nxt;
    logic [ROM_ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]            r_wdata, w_wdata_nxt;

    logic                  w_rd_edge, w_wr_edge;
    logic                  w_is_rom, w_is_ram;
    logic [1:0]            w_hi_sel;
    logic [31:0]           w_rom_full, w_ram_full;
    logic [RAM_ADDR_W-1:0] w_ram_trunc;
    logic [ROM_ADDR_W-1:0] w_rom_addr, w_ram_addr;

    // Edge detect on the synchronized strobes.
    assign w_rd_edge = r_rd_s2 & ~r_rd_d;
    assign w_wr_edge = r_wr_s2 & ~r_wr_d;

    assign w_is_rom = ~bus_a[15];
    assign w_is_ram = (bus_a[15:13] == 3'b101) & bus_cs;
    assign w_hi_sel = r_mode ? r_bank_hi : 2'b00;

    // Bank 0 window uses bank_hi only in mode 1.
    assign w_rom_full = bus_a[14]
        ? {11'd0, r_bank_hi, r_rom_bank_lo, bus_a[13:0]}
        : {11'd0, w_hi_sel, 5'd0, bus_a[13:0]};
    assign w_ram_full  = {17'd0, w_hi_sel, bus_a[12:0]};
    assign w_rom_addr  = w_rom_full[ROM_ADDR_W-1:0];
    assign w_ram_trunc = w_ram_full[RAM_ADDR_W-1:0];
    assign w_ram_addr  = ROM_ADDR_W'(w_ram_trunc);

    always_comb begin
        w_state_nxt       = r_state;
        w_ram_en_nxt      = r_ram_en;
        w_rom_bank_lo_nxt = r_rom_bank_lo;
        w_bank_hi_nxt     = r_bank_hi;
        w_mode_nxt        = r_mode;
        w_dout_nxt        = r_dout;
        w_dout_en_nxt     = r_dout_en;
        w_req_nxt         = r_req;
        w_we_nxt          = r_we;
        w_sel_nxt         = r_sel;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        unique case (r_state)
            IDLE: begin
                // Write takes priority over a simultaneous read edge.
                if (w_wr_edge) begin
                    w_state_nxt = HOLD;
                    if (w_is_ram && r_ram_en) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b1;
                        w_sel_nxt   = 1'b1;
                        w_addr_nxt  = w_ram_addr;
                        w_wdata_nxt = bus_din;
                        w_state_nxt = WR_WAIT;
                    end else if (w_is_rom) begin
                        unique case (bus_a[14:13])
                            2'b00: w_ram_en_nxt = (bus_din[3:0] == 4'hA);
                            2'b01: w_rom_bank_lo_nxt =
                                (bus_din[4:0] == 5'd0) ? 5'd1 : bus_din[4:0];
                            2'b10: w_bank_hi_nxt = bus_din[1:0];
                            2'b11: w_mode_nxt = bus_din[0];
                        endcase
                    end
                end else if (w_rd_edge) begin
                    if (w_is_rom) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_sel_nxt   = 1'b0;
                        w_addr_nxt  = w_rom_addr;
                        w_state_nxt = RD_WAIT;
                    end else if (w_is_ram && r_ram_en) begin
                        w_req_nxt   = 1'b1;
                        w_we_nxt    = 1'b0;
                        w_sel_nxt   = 1'b1;
                        w_addr_nxt  = w_ram_addr;
                        w_state_nxt = RD_WAIT;
                    end else begin
                        w_dout_nxt    = 8'hFF;
                        w_dout_en_nxt = 1'b1;
                        w_state_nxt   = HOLD;
                    end
                end
            end
            RD_WAIT: begin
                if (mem_ack) begin
                    w_dout_nxt    = mem_rdata;
                    w_dout_en_nxt = 1'b1;
                    w_req_nxt     = 1'b0;
                    w_state_nxt   = HOLD;
                end
            end
            WR_WAIT: begin
                if (mem_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!r_rd_s2 && !r_wr_s2) begin
                    w_dout_en_nxt = 1'b0;
                    w_state_nxt   = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd_s1       <= 1'b0;
            r_rd_s2       <= 1'b0;
            r_rd_d        <= 1'b0;
            r_wr_s1       <= 1'b0;
            r_wr_s2       <= 1'b0;
            r_wr_d        <= 1'b0;
            r_ram_en      <= 1'b0;
            r_rom_bank_lo <= 5'd1;
            r_bank_hi     <= 2'd0;
            r_mode        <= 1'b0;
            r_dout        <= 8'hFF;
            r_dout_en     <= 1'b0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_sel         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_rd_s1       <= bus_rd;
            r_rd_s2       <= r_rd_s1;
            r_rd_d        <= r_rd_s2;
            r_wr_s1       <= bus_wr;
            r_wr_s2       <= r_wr_s1;
            r_wr_d        <= r_wr_s2;
            r_ram_en      <= w_ram_en_nxt;
            r_rom_bank_lo <= w_rom_bank_lo_nxt;
            r_bank_hi     <= w_bank_hi_nxt;
            r_mode        <= w_mode_nxt;
            r_dout        <= w_dout_nxt;
            r_dout_en     <= w_dout_en_nxt;
            r_req         <= w_req_nxt;
            r_we          <= w_we_nxt;
            r_sel         <= w_sel_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
        end
    end

    assign bus_dout    = r_dout;
    assign bus_dout_en = r_dout_en;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mem_sel     = r_sel;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule

// File: tb/tb_gb_cart_mbc1.sv
// Directed testbench for gb_cart_mbc1.
// Drives bus strobes and a req/ack memory model on negedges.
module tb_gb_cart_mbc1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_a;
    logic [7:0]  bus_din;
    logic        bus_rd, bus_wr, bus_cs;
    logic [7:0]  bus_dout;
    logic        bus_dout_en;
    logic        mem_req, mem_sel, mem_we;
    logic [20:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gb_cart_mbc1 #(.ROM_ADDR_W(21), .RAM_ADDR_W(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_a(bus_a), .bus_din(bus_din),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_cs(bus_cs),
        .bus_dout(bus_dout), .bus_dout_en(bus_dout_en),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_req(output int c);
        c = 0;
        while (!mem_req && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic wait_idle(output int c);
        c = 0;
        while (bus_dout_en && c < 10) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic rd_mem(input string tag, input logic [15:0] a,
                          input logic cs, input logic [20:0] ea,
                          input logic es, input logic [7:0] d,
                          output int lat);
        int c;
        @(negedge clk);
        bus_a = a; bus_cs = cs; bus_rd = 1'b1;
        wait_req(lat);
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        chk({tag, ".addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ".sel"}, 32'(mem_sel), 32'(es));
        chk({tag, ".we"}, 32'(mem_we), 32'd0);
        repeat (3) @(negedge clk);
        chk({tag, ".hold"}, 32'(mem_req), 32'd1);
        mem_rdata = d; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = 8'h00;
        chk({tag, ".reqdn"}, 32'(mem_req), 32'd0);
        chk({tag, ".en"}, 32'(bus_dout_en), 32'd1);
        chk({tag, ".dout"}, 32'(bus_dout), 32'(d));
        repeat (2) @(negedge clk);
        chk({tag, ".en2"}, 32'(bus_dout_en), 32'd1);
        bus_rd = 1'b0;
        wait_idle(c);
        chk({tag, ".endn"}, 32'(bus_dout_en), 32'd0);
        chk({tag, ".keep"}, 32'(bus_dout), 32'(d));
    endtask

    task automatic rd_ff(input string tag, input logic [15:0] a,
                         input logic cs);
        int c;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus_a = a; bus_cs = cs; bus_rd = 1'b1;
        c = 0;
        while (!bus_dout_en && c < 8) begin
            @(negedge clk);
            c++;
            if (mem_req) seen = 1'b1;
        end
        chk({tag, ".en"}, 32'(bus_dout_en), 32'd1);
        chk({tag, ".dout"}, 32'(bus_dout), 32'hFF);
        chk({tag, ".noreq"}, 32'(seen), 32'd0);
        chk({tag, ".lat"}, 32'(c <= 4), 32'd1);
        bus_rd = 1'b0;
        wait_idle(c);
        chk({tag, ".endn"}, 32'(bus_dout_en), 32'd0);
    endtask

    task automatic wr_reg(input string tag, input logic [15:0] a,
                          input logic [7:0] d);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        bus_a = a; bus_din = d; bus_cs = 1'b0; bus_wr = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (mem_req || bus_dout_en) seen = 1'b1;
        end
        bus_wr = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, ".quiet"}, 32'(seen), 32'd0);
    endtask

    task automatic wr_ram(input string tag, input logic [15:0] a,
                          input logic [7:0] d, input logic [20:0] ea);
        int c;
        @(negedge clk);
        bus_a = a; bus_din = d; bus_cs = 1'b1; bus_wr = 1'b1;
        wait_req(c);
        chk({tag, ".req"}, 32'(mem_req), 32'd1);
        chk({tag, ".we"}, 32'(mem_we), 32'd1);
        chk({tag, ".sel"}, 32'(mem_sel), 32'd1);
        chk({tag, ".addr"}, 32'(mem_addr), 32'(ea));
        chk({tag, ".wdata"}, 32'(mem_wdata), 32'(d));
        repeat (2) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk({tag, ".reqdn"}, 32'(mem_req), 32'd0);
        chk({tag, ".noen"}, 32'(bus_dout_en), 32'd0);
        bus_wr = 1'b0; bus_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int lat;
        int c;
        logic seen;
        rst_n = 1'b0;
        bus_a = 16'h0; bus_din = 8'h0;
        bus_rd = 1'b0; bus_wr = 1'b0; bus_cs = 1'b0;
        mem_rdata = 8'h0; mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.dout", 32'(bus_dout), 32'hFF);
        chk("rst.en", 32'(bus_dout_en), 32'd0);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.addr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1;

        rd_mem("rd150", 16'h0150, 1'b0, 21'h000150, 1'b0, 8'h3C, lat);
        chk("rd150.lat", 32'(lat), 32'd3);

        wr_reg("lo0", 16'h2000, 8'h00);
        rd_mem("rd4000", 16'h4000, 1'b0, 21'h004000, 1'b0, 8'h11, lat);
        wr_reg("lo13", 16'h2000, 8'h13);
        wr_reg("hi2", 16'h4000, 8'h02);
        rd_mem("rd7fff", 16'h7FFF, 1'b0, 21'h14FFFF, 1'b0, 8'hA5, lat);

        rd_ff("ramoff", 16'hA000, 1'b1);
        rd_ff("unmap", 16'hC000, 1'b0);

        wr_reg("ramen", 16'h0000, 8'h0A);
        wr_reg("mode1", 16'h6000, 8'h01);
        wr_reg("hi3", 16'h4000, 8'h03);
        wr_ram("wrram", 16'hA123, 8'h55, 21'h006123);
        rd_mem("rdram", 16'hA123, 1'b1, 21'h006123, 1'b1, 8'h9A, lat);
        rd_ff("nocs", 16'hA123, 1'b0);

        wr_reg("hi1", 16'h4000, 8'h01);
        rd_mem("m1b0", 16'h0000, 1'b0, 21'h080000, 1'b0, 8'h42, lat);
        wr_reg("mode0", 16'h6000, 8'h00);
        rd_mem("m0b0", 16'h0000, 1'b0, 21'h000000, 1'b0, 8'h24, lat);

        // Strobe drops while the memory is still busy.
        @(negedge clk);
        bus_a = 16'h0200; bus_cs = 1'b0; bus_rd = 1'b1;
        wait_req(c);
        chk("early.req", 32'(mem_req), 32'd1);
        bus_rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("early.hold", 32'(mem_req), 32'd1);
        mem_rdata = 8'h77; mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("early.en", 32'(bus_dout_en), 32'd1);
        chk("early.dout", 32'(bus_dout), 32'h77);
        @(negedge clk);
        chk("early.pulse", 32'(bus_dout_en), 32'd0);
        repeat (2) @(negedge clk);

        // Simultaneous rd/wr edges: the write is taken.
        seen = 1'b0;
        @(negedge clk);
        bus_a = 16'h2000; bus_din = 8'h05; bus_rd = 1'b1; bus_wr = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (mem_req || bus_dout_en) seen = 1'b1;
        end
        chk("both.quiet", 32'(seen), 32'd0);
        bus_rd = 1'b0; bus_wr = 1'b0;
        repeat (4) @(negedge clk);
        rd_mem("both.rd", 16'h4000, 1'b0, 21'h094000, 1'b0, 8'h5A, lat);

        // Stray ack in IDLE must not disturb anything.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'h33;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("stray.en", 32'(bus_dout_en), 32'd0);
        chk("stray.dout", 32'(bus_dout), 32'h5A);

        // Reset in the middle of a read.
        @(negedge clk);
        bus_a = 16'h4000; bus_rd = 1'b1;
        wait_req(c);
        chk("mid.req", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.reqdn", 32'(mem_req), 32'd0);
        chk("mid.addr", 32'(mem_addr), 32'd0);
        chk("mid.dout", 32'(bus_dout), 32'hFF);
        @(negedge clk);
        bus_rd = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rd_mem("post", 16'h4000, 1'b0, 21'h004000, 1'b0, 8'hC3, lat);
        rd_ff("postram", 16'hA000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
